// File: rtl/tdc_channel_ctrl.sv
// Per-channel TDC controller: arms/clears the delay line, synchronizes the hit,
// and emits a {bubble, coarse, fine} timestamp over a valid/ready interface.
module tdc_channel_ctrl #(
  parameter int unsigned NTAPS    = 4,
  parameter int unsigned COARSE_W = 16,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable_i,
  input  logic                                hit_flag_i,
  input  logic [NTAPS-1:0]                    taps_i,
  output logic                                dl_clr_o,
  output logic [COARSE_W+$clog2(NTAPS+1):0]   ts_data_o,
  output logic                                ts_valid_o,
  input  logic                                ts_ready_i,
  output logic                                busy_o,
  output logic                                rollover_o
);

  localparam int unsigned FINE_W = $clog2(NTAPS + 1);
  localparam int unsigned TS_W   = 1 + COARSE_W + FINE_W;
  localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_OUTPUT,
    S_CLEAR
  } state_e;

  state_e              state_q;
  logic [COARSE_W-1:0] cnt_q;
  logic [COARSE_W-1:0] cnt_d;
  logic [COARSE_W-1:0] coarse_q;
  logic                rollover_q;
  logic                hit_meta_q;
  logic                hit_s_q;
  logic [NTAPS-1:0]    taps_meta_q;
  logic [NTAPS-1:0]    taps_s_q;
  logic [DEAD_W-1:0]   dead_q;
  logic                dl_clr_q;
  logic                ts_valid_q;
  logic                busy_q;
  logic [TS_W-1:0]     ts_data_q;
  logic [FINE_W-1:0]   fine_c;
  logic                bubble_c;

  assign cnt_d = cnt_q + COARSE_W'(1);

  // Free-running coarse counter; rollover flags the cycle it reads 0 after a wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rollover_q <= (cnt_d == '0);
    end
  end

  // Two-flop synchronizers for the asynchronous hit flag and thermometer code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_meta_q  <= 1'b0;
      hit_s_q     <= 1'b0;
      taps_meta_q <= '0;
      taps_s_q    <= '0;
    end else begin
      hit_meta_q  <= hit_flag_i;
      hit_s_q     <= hit_meta_q;
      taps_meta_q <= taps_i;
      taps_s_q    <= taps_meta_q;
    end
  end

  // Fine value is the popcount of the synchronized code
  always_comb begin
    fine_c = '0;
    for (int i = 0; i < NTAPS; i++) begin
      fine_c = fine_c + FINE_W'(taps_s_q[i]);
    end
  end

  // A legal code 0..01..1 plus one has no bit in common with itself
  assign bubble_c = |(taps_s_q & (taps_s_q + NTAPS'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      coarse_q   <= '0;
      dead_q     <= '0;
      dl_clr_q   <= 1'b1;
      ts_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ts_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q  <= S_ARMED;
            dl_clr_q <= 1'b0;
          end
        end
        S_ARMED: begin
          // Hit wins over a simultaneous disable; undo the two sync stages
          if (hit_s_q) begin
            state_q  <= S_CAPTURE;
            coarse_q <= cnt_d - COARSE_W'(2);
            busy_q   <= 1'b1;
          end else if (!enable_i) begin
            state_q  <= S_IDLE;
            dl_clr_q <= 1'b1;
          end
        end
        S_CAPTURE: begin
          state_q    <= S_OUTPUT;
          ts_data_q  <= {bubble_c, coarse_q, fine_c};
          ts_valid_q <= 1'b1;
        end
        S_OUTPUT: begin
          if (ts_ready_i) begin
            state_q    <= S_CLEAR;
            ts_valid_q <= 1'b0;
            dl_clr_q   <= 1'b1;
            dead_q     <= DEAD_W'(DEAD_CYC - 1);
          end
        end
        S_CLEAR: begin
          if (dead_q != '0) begin
            dead_q <= dead_q - DEAD_W'(1);
          end else if (!hit_s_q) begin
            busy_q <= 1'b0;
            if (enable_i) begin
              state_q  <= S_ARMED;
              dl_clr_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          dl_clr_q   <= 1'b1;
          ts_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign dl_clr_o   = dl_clr_q;
  assign ts_data_o  = ts_data_q;
  assign ts_valid_o = ts_valid_q;
  assign busy_o     = busy_q;
  assign rollover_o = rollover_q;

endmodule
